// File: rtl/l2_line_responder_pkg.sv
// Shared geometry, read/write encodings and FSM state type for the L2 line responder.
package l2_line_responder_pkg;
  localparam int ADDR_WIDTH         = 32;
  localparam int DATA_WIDTH         = 32;
  localparam int WORDS              = 8;
  localparam int LINE_W             = DATA_WIDTH * WORDS;
  localparam int LINE_BITS          = 5;
  localparam int MSHR_ID_BITS       = 4;
  localparam int DEF_MEM_INDEX_BITS = 10;
  localparam int DEF_QUEUE_DEPTH    = 4;
  localparam int DEF_LATENCY        = 4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/l2_line_responder_if.sv
// L1 <-> L2 line request/response bus; the L1 side is the master.
interface l2_line_responder_if
  import l2_line_responder_pkg::*;
  ();
  logic [ADDR_WIDTH-1:0]   addr;
  logic [LINE_W-1:0]       wdata;
  logic                    rw;
  logic                    valid;
  logic [MSHR_ID_BITS-1:0] id;
  logic                    stall;
  logic [LINE_W-1:0]       rdata;
  logic                    rsp_valid;
  logic [MSHR_ID_BITS-1:0] rsp_id;

  modport master (
    output addr, wdata, rw, valid, id,
    input  stall, rdata, rsp_valid, rsp_id
  );

  modport slave (
    input  addr, wdata, rw, valid, id,
    output stall, rdata, rsp_valid, rsp_id
  );
endinterface

// File: rtl/l2_line_responder_req_fifo.sv
// In-order request queue; DEPTH must be a power of two so pointers wrap for free.
module l2_line_responder_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/l2_line_responder.sv
// L2 line responder: queues line reads/writes, services them against a line RAM after a
// fixed latency, and answers each with one in-order response pulse.
//   state     | meaning
//   ST_IDLE   | waiting for a queued request; pops the head when one is present
//   ST_ACCESS | latency down-counter running; RAM access at terminal count
//   ST_RESP   | response pulse on rsp_valid for one cycle
module l2_line_responder
  import l2_line_responder_pkg::*;
#(
  parameter int MEM_INDEX_BITS = DEF_MEM_INDEX_BITS,
  parameter int QUEUE_DEPTH    = DEF_QUEUE_DEPTH,
  parameter int LATENCY        = DEF_LATENCY
) (
  input logic                clk,
  input logic                reset,
  l2_line_responder_if.slave l2
);
  localparam int ENTRY_W = MEM_INDEX_BITS + LINE_W + 1 + MSHR_ID_BITS;
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LINES   = 1 << MEM_INDEX_BITS;

  state_t                    state;
  state_t                    state_next;
  logic                      pop;
  logic                      access_done;
  logic [CNT_W-1:0]          cnt;

  logic [ENTRY_W-1:0]        fifo_din;
  logic [ENTRY_W-1:0]        fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;

  logic [MEM_INDEX_BITS-1:0] head_idx;
  logic [LINE_W-1:0]         head_data;
  logic                      head_rw;
  logic [MSHR_ID_BITS-1:0]   head_id;

  logic [MEM_INDEX_BITS-1:0] work_idx;
  logic [LINE_W-1:0]         work_data;
  logic                      work_rw;
  logic [MSHR_ID_BITS-1:0]   work_id;

  logic [LINE_W-1:0]         ram [LINES];

  // Only the index bits are queued; higher address bits alias onto the same line.
  assign fifo_din = {l2.addr[LINE_BITS+MEM_INDEX_BITS-1:LINE_BITS], l2.wdata, l2.rw, l2.id};
  assign {head_idx, head_data, head_rw, head_id} = fifo_dout;

  l2_line_responder_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (l2.valid & ~fifo_full),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign l2.stall     = fifo_full;
  assign l2.rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    access_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt == '0) begin
          access_done = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      work_idx  <= '0;
      work_data <= '0;
      work_rw   <= RW_READ;
      work_id   <= '0;
      l2.rdata  <= '0;
      l2.rsp_id <= '0;
    end else begin
      if (pop) begin
        work_idx  <= head_idx;
        work_data <= head_data;
        work_rw   <= head_rw;
        work_id   <= head_id;
        cnt       <= CNT_W'(LATENCY - 1);
      end else if (state == ST_ACCESS && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access_done) begin
        l2.rsp_id <= work_id;
        l2.rdata  <= (work_rw == RW_WRITE) ? '0 : ram[work_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (access_done && work_rw == RW_WRITE) ram[work_idx] <= work_data;
  end
endmodule
